// File: rtl/scan_test_controller.sv
// Scan test controller: scans a state vector into the CUT chain, runs one capture cycle,
// then compares the unloaded chain and sampled POs against the expected values.
module scan_test_controller #(
  parameter int unsigned NFF  = 56,
  parameter int unsigned PI_W = 8,
  parameter int unsigned PO_W = 17
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            vec_valid,
  output logic            vec_ready,
  input  logic [PI_W-1:0] vec_pi,
  input  logic [NFF-1:0]  vec_st,
  input  logic [PO_W-1:0] vec_po,
  output logic            NbarT,
  output logic            Si,
  input  logic            So,
  output logic [PI_W-1:0] pi_out,
  input  logic [PO_W-1:0] po_in,
  output logic            res_valid,
  output logic            res_fail,
  output logic [15:0]     fail_cnt,
  output logic [15:0]     vec_cnt
);

  localparam int unsigned   CW      = $clog2(NFF + 1);
  localparam logic [CW-1:0] LastCnt = CW'(NFF - 1);

  typedef enum logic [1:0] {StIdle, StShift, StCapture, StCompare} state_e;

  state_e          r_state;
  logic [CW-1:0]   r_cnt;
  logic [NFF-1:0]  r_ld, r_unl, r_prev_st;
  logic [PO_W-1:0] r_exp_po, r_po_smp;
  logic [PI_W-1:0] r_pi;
  logic            r_prev_ok, r_nbart, r_si, r_res_valid;
  logic [15:0]     r_fail_cnt, r_vec_cnt;

  logic            w_accept, w_res_fail;
  logic [NFF-1:0]  w_ld_rot, w_unl_nxt;

  // Rotating the load register keeps the next scan bit at index 0; after NFF
  // rotations it holds the original vector again, ready to become prev_st.
  assign w_ld_rot   = (r_ld >> 1) | (r_ld << (NFF - 1));
  assign w_unl_nxt  = NFF'({So, r_unl} >> 1);
  assign w_res_fail = (r_prev_ok & (r_unl != r_prev_st)) | (r_po_smp != r_exp_po);
  assign vec_ready  = (r_state == StIdle) & ~clear;
  assign w_accept   = vec_valid & vec_ready;

  assign NbarT     = r_nbart;
  assign Si        = r_si;
  assign pi_out    = r_pi;
  assign res_valid = r_res_valid & ~clear;
  assign res_fail  = r_res_valid & w_res_fail;
  assign fail_cnt  = r_fail_cnt;
  assign vec_cnt   = r_vec_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_ld        <= '0;
      r_unl       <= '0;
      r_prev_st   <= '0;
      r_exp_po    <= '0;
      r_po_smp    <= '0;
      r_pi        <= '0;
      r_prev_ok   <= 1'b0;
      r_nbart     <= 1'b1;
      r_si        <= 1'b0;
      r_res_valid <= 1'b0;
      r_fail_cnt  <= '0;
      r_vec_cnt   <= '0;
    end else if (clear) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_prev_ok   <= 1'b0;
      r_nbart     <= 1'b1;
      r_si        <= 1'b0;
      r_res_valid <= 1'b0;
      r_fail_cnt  <= '0;
      r_vec_cnt   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_pi     <= vec_pi;
            r_ld     <= vec_st;
            r_exp_po <= vec_po;
            r_cnt    <= '0;
            r_si     <= vec_st[0];
            r_state  <= StShift;
          end
        end
        StShift: begin
          r_unl <= w_unl_nxt;
          r_ld  <= w_ld_rot;
          if (r_cnt == LastCnt) begin
            r_nbart <= 1'b0;
            r_si    <= 1'b0;
            r_state <= StCapture;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            r_si  <= w_ld_rot[0];
          end
        end
        StCapture: begin
          r_po_smp    <= po_in;
          r_nbart     <= 1'b1;
          r_res_valid <= 1'b1;
          r_state     <= StCompare;
        end
        StCompare: begin
          r_res_valid <= 1'b0;
          r_prev_st   <= r_ld;
          r_prev_ok   <= 1'b1;
          r_vec_cnt   <= r_vec_cnt + 16'd1;
          if (w_res_fail && (r_fail_cnt != 16'hFFFF)) r_fail_cnt <= r_fail_cnt + 16'd1;
          r_state     <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule
